morse_symbol_sequencer: RTL

//  Times a single Morse key line, classifies each press as dot or dash, and packs up to 4

---
 rtl/morse_pkg.sv | 32 +++
 rtl/morse_symbol_sequencer_if.sv | 15 +
 rtl/morse_key_timer.sv | 72 +++++++
 rtl/morse_symbol_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse symbol sequencer: symbol codes, FSM states,
// packed-word type and a slot-insertion helper.
package morse_pkg;

    typedef logic [1:0] sym_t;
    typedef logic [7:0] sym_word_t;

    localparam sym_t SYM_GAP  = 2'b00;
    localparam sym_t SYM_DOT  = 2'b01;
    localparam sym_t SYM_DASH = 2'b11;

    localparam int MAX_SYMBOLS = 4;
    localparam int COUNT_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_RELEASE = 2'd2,
        ST_EMIT    = 2'd3
    } state_t;

    // Slot 0 lives in [7:6], slot 3 in [1:0].
    function automatic sym_word_t place_symbol(sym_word_t word, logic [1:0] slot, sym_t sym);
        sym_word_t r;
        int        base;
        r    = word;
        base = 6 - 2 * int'(slot);
        r[base +: 2] = sym;
        return r;
    endfunction

endpackage

// File: rtl/morse_symbol_sequencer_if.sv
// Letter handshake bundle: the sequencer (master) offers a packed symbol word,
// the decoder side (slave) accepts it with ready.
interface morse_symbol_sequencer_if;
    import morse_pkg::*;

    sym_word_t          word;
    logic               valid;
    logic               ready;
    logic [COUNT_W-1:0] count;
    logic               overflow;

    modport master (output word, output valid, output count, output overflow, input ready);
    modport slave  (input word, input valid, input count, input overflow, output ready);

endinterface

// File: rtl/morse_key_timer.sv
// Key conditioning, edge detection and saturating press/gap counters.
// With INPUT_SYNC_EN defined the key passes a 2-flop synchronizer first.
module morse_key_timer #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_key_raw,
    input  logic             i_press_load,
    input  logic             i_press_inc,
    input  logic             i_gap_clr,
    input  logic             i_gap_inc,
    output logic             o_key,
    output logic             o_rise,
    output logic             o_fall,
    output logic [CNT_W-1:0] o_press_cnt,
    output logic [CNT_W-1:0] o_gap_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             w_key;
    logic             r_key_prev;
    logic [CNT_W-1:0] r_press_cnt;
    logic [CNT_W-1:0] r_gap_cnt;

`ifdef INPUT_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_key_raw};
        end
    end

    assign w_key = r_sync[1];
`else
    assign w_key = i_key_raw;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_key_prev  <= 1'b0;
            r_press_cnt <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_key_prev <= w_key;

            if (i_press_load) begin
                r_press_cnt <= CNT_ONE;
            end else if (i_press_inc && (r_press_cnt != CNT_MAX)) begin
                r_press_cnt <= r_press_cnt + CNT_ONE;
            end

            if (i_gap_clr) begin
                r_gap_cnt <= '0;
            end else if (i_gap_inc && (r_gap_cnt != CNT_MAX)) begin
                r_gap_cnt <= r_gap_cnt + CNT_ONE;
            end
        end
    end

    assign o_key       = w_key;
    assign o_rise      = w_key & ~r_key_prev;
    assign o_fall      = ~w_key & r_key_prev;
    assign o_press_cnt = r_press_cnt;
    assign o_gap_cnt   = r_gap_cnt;

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Classifies key presses as dot/dash, packs up to four symbols per letter and
// offers the word after the letter gap. Optional INPUT_SYNC_EN adds a key synchronizer.
module morse_symbol_sequencer
    import morse_pkg::*;
#(
    parameter int CNT_W            = 16,
    parameter int MIN_PRESS_TICKS  = 2,
    parameter int DOT_MAX_TICKS    = 4,
    parameter int LETTER_GAP_TICKS = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_key,
    morse_symbol_sequencer_if.master  sym_bus
);

    localparam logic [CNT_W-1:0]   MIN_CNT  = CNT_W'(MIN_PRESS_TICKS);
    localparam logic [CNT_W-1:0]   DOT_CNT  = CNT_W'(DOT_MAX_TICKS);
    // Gap counter value from which one more low cycle completes the letter gap.
    localparam logic [CNT_W-1:0]   GAP_LAST = CNT_W'(LETTER_GAP_TICKS - 2);
    localparam logic [COUNT_W-1:0] MAX_CNT  = COUNT_W'(MAX_SYMBOLS);

    state_t             r_state,    w_state_next;
    sym_word_t          r_word,     w_word_next;
    logic [COUNT_W-1:0] r_count,    w_count_next;
    logic               r_overflow, w_overflow_next;

    logic             w_press_load, w_press_inc, w_gap_clr, w_gap_inc;
    logic             w_key, w_rise, w_fall;
    logic [CNT_W-1:0] w_press_cnt, w_gap_cnt;

    morse_key_timer #(
        .CNT_W (CNT_W)
    ) u_key_timer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_key_raw    (i_key),
        .i_press_load (w_press_load),
        .i_press_inc  (w_press_inc),
        .i_gap_clr    (w_gap_clr),
        .i_gap_inc    (w_gap_inc),
        .o_key        (w_key),
        .o_rise       (w_rise),
        .o_fall       (w_fall),
        .o_press_cnt  (w_press_cnt),
        .o_gap_cnt    (w_gap_cnt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_word     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_word     <= w_word_next;
            r_count    <= w_count_next;
            r_overflow <= w_overflow_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_word_next     = r_word;
        w_count_next    = r_count;
        w_overflow_next = r_overflow;
        w_press_load    = 1'b0;
        w_press_inc     = 1'b0;
        w_gap_clr       = 1'b0;
        w_gap_inc       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_next = ST_PRESS;
                    w_press_load = 1'b1;
                end
            end

            ST_PRESS: begin
                if (w_fall) begin
                    if (w_press_cnt < MIN_CNT) begin
                        // Glitch: gap timing resumes where it left off.
                        w_state_next = (r_count == '0) ? ST_IDLE : ST_RELEASE;
                    end else begin
                        if (r_count < MAX_CNT) begin
                            w_word_next  = place_symbol(r_word, r_count[1:0],
                                                        (w_press_cnt <= DOT_CNT) ? SYM_DOT : SYM_DASH);
                            w_count_next = r_count + COUNT_W'(1);
                        end else begin
                            w_overflow_next = 1'b1;
                        end
                        w_gap_clr    = 1'b1;
                        w_state_next = ST_RELEASE;
                    end
                end else begin
                    w_press_inc = 1'b1;
                end
            end

            ST_RELEASE: begin
                if (w_rise) begin
                    w_state_next = ST_PRESS;
                    w_press_load = 1'b1;
                end else begin
                    w_gap_inc = 1'b1;
                    if (w_gap_cnt >= GAP_LAST) begin
                        w_state_next = ST_EMIT;
                    end
                end
            end

            ST_EMIT: begin
                // Key activity while waiting is ignored; only its level at acceptance counts.
                if (sym_bus.ready) begin
                    w_word_next     = '0;
                    w_count_next    = '0;
                    w_overflow_next = 1'b0;
                    if (w_key) begin
                        w_state_next = ST_PRESS;
                        w_press_load = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign sym_bus.valid    = (r_state == ST_EMIT);
    assign sym_bus.word     = ((r_state == ST_EMIT) && r_overflow) ? sym_word_t'(0) : r_word;
    assign sym_bus.count    = r_count;
    assign sym_bus.overflow = r_overflow;

endmodule
